// File: rtl/prm_pkg.sv
// Shared defaults and state encoding for the PRM edge-mask collector.
package prm_pkg;

  localparam int NUM_EDGES_DEF = 1024;
  localparam int WORD_W_DEF    = 32;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/prm_mask_serializer.sv
// Picks word k of the latched blocked-edge vector and flags the final word.
module prm_mask_serializer #(
  parameter int NUM_EDGES = 1024,
  parameter int WORD_W    = 32,
  localparam int NUM_WORDS = NUM_EDGES / WORD_W,
  localparam int K_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic [NUM_EDGES-1:0] result,
  input  logic [K_W-1:0]       k,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_last
);

  logic [NUM_WORDS-1:0][WORD_W-1:0] words;

  assign words    = result;
  assign out_data = words[k];
  assign out_last = (k == K_W'(NUM_WORDS - 1));

endmodule

// File: rtl/prm_edge_mask_collector.sv
// ORs per-voxel edge collision masks over a frame, then streams the blocked-edge
// vector out word by word while counting the voxels that contributed.
module prm_edge_mask_collector
  import prm_pkg::*;
#(
  parameter int NUM_EDGES = NUM_EDGES_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_EDGES-1:0] in_mask,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_last,
  output logic [CNT_W-1:0]     voxel_count
);

  localparam int NUM_WORDS = NUM_EDGES / WORD_W;
  localparam int K_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state, state_nxt;
  logic [NUM_EDGES-1:0] acc;
  logic [NUM_EDGES-1:0] result;
  logic [CNT_W-1:0]     run_cnt;
  logic [K_W-1:0]       k;
  logic                 ser_last;
  logic                 accept;
  logic                 handshake;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && in_last)      state_nxt = DRAIN;
      DRAIN: if (handshake && ser_last)  state_nxt = ACCUM;
      default:                           state_nxt = ACCUM;
    endcase
  end

  // Handshake outputs depend on state only, so no in_* -> out_* or out_ready -> in_ready path.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) & ser_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      result      <= '0;
      run_cnt     <= '0;
      voxel_count <= '0;
      k           <= '0;
    end else begin
      if (accept) begin
        if (in_last) begin
          result      <= acc | in_mask;
          voxel_count <= sat_inc(run_cnt);
          acc         <= '0;
          run_cnt     <= '0;
        end else begin
          acc     <= acc | in_mask;
          run_cnt <= sat_inc(run_cnt);
        end
      end
      if (handshake) k <= ser_last ? '0 : k + 1'b1;
    end
  end

  prm_mask_serializer #(
    .NUM_EDGES(NUM_EDGES),
    .WORD_W   (WORD_W)
  ) u_ser (
    .result  (result),
    .k       (k),
    .out_data(out_data),
    .out_last(ser_last)
  );

endmodule

// File: doc/prm_edge_mask_collector.md
PRM_EDGE_MASK_COLLECTOR -- requirements
Module: prm_edge_mask_collector

Interface
REQ-001 SHALL have parameter NUM_EDGES, default 1024: number of roadmap edges checked in parallel, one prm_oblgc_chk instance per edge.
REQ-002 SHALL have parameter WORD_W, default 32: output word width; NUM_EDGES SHALL be a multiple of WORD_W.
REQ-003 SHALL have parameter CNT_W, default 16: voxel counter width.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  current obstacle voxel's edge_mask vector is valid.
REQ-007 in_ready  output  1  block accepts an input beat this cycle.
REQ-008 in_mask  input  NUM_EDGES  edge_mask outputs of all checkers for the current voxel; bit i = 1 means edge i collides with the voxel.
REQ-009 in_last  input  1  current beat is the last voxel of the frame.
REQ-010 out_valid  output  1  out_data holds a valid blocked-edge word.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  WORD_W  blocked-edge bits [k*WORD_W +: WORD_W] for word index k.
REQ-013 out_last  output  1  asserted with the final word (k = NUM_EDGES/WORD_W-1).
REQ-014 voxel_count  output  CNT_W  voxels accepted in the last completed frame, saturating.

Function
REQ-015 SHALL implement two states: ACCUM and DRAIN.
REQ-016 ACCUM: in_ready=1, out_valid=0; accepted beat (in_valid&in_ready) SHALL update acc <= acc | in_mask and increment running count (saturate at 2^CNT_W-1).
REQ-017 Accepted beat with in_last=1 SHALL load result <= acc | in_mask, voxel_count <= running count + 1 (saturating), clear acc and running count to 0, and move to DRAIN on the next cycle.
REQ-018 Single-beat frame (first beat has in_last=1) SHALL be legal and yield result = in_mask, voxel_count = 1.
REQ-019 DRAIN: in_ready=0, out_valid=1, out_data = result word k, k starting at 0; in_valid ignored.
REQ-020 Handshake out_valid&out_ready SHALL increment k; out_data/out_last SHALL hold stable while out_ready=0.
REQ-021 Handshake on final word (out_last=1) SHALL return to ACCUM with k=0; in_ready=1 on the following cycle.
REQ-022 Latency: first output word valid exactly 1 cycle after the in_last beat is accepted; full drain takes NUM_EDGES/WORD_W handshakes minimum.
REQ-023 voxel_count SHALL hold its value until the next frame completes.
REQ-024 No combinational path from in_* to out_* or from out_ready to in_ready.

Reset
REQ-025 rst=1 SHALL force state ACCUM, acc=0, result=0, k=0, running count=0, voxel_count=0, out_valid=0, out_last=0, out_data=0, in_ready=1 on the next edge.
REQ-026 rst during ACCUM or DRAIN SHALL discard the partial frame and pending words; no out_valid after reset until a new in_last beat.

Structure
REQ-027 Package prm_pkg SHALL hold NUM_EDGES, WORD_W, CNT_W defaults and the state enum (ACCUM, DRAIN).
REQ-028 Word selection and out_last generation SHALL live in one sub-module prm_mask_serializer (inputs result, k; outputs out_data, out_last).

Verification
REQ-029 Reset, then 3 beats masks bit0, bit33, bit1023, last on 3rd -> words 0 = 0x00000001, 1 = 0x00000002, 31 = 0x80000000, others 0; voxel_count=3.
REQ-030 Single beat all-ones with in_last, out_ready=1 -> 32 words 0xFFFFFFFF, out_last only on 32nd, in_ready high cycle after.
REQ-031 DRAIN with out_ready toggling 1/0 each cycle plus in_valid=1 held -> out_data stable while stalled, no input accepted, 32 words in 63 cycles.
REQ-032 Two back-to-back frames (masks 0x1 then 0x2 in word 0) -> second frame outputs word 0 = 0x00000002 (acc cleared between frames).
REQ-033 rst asserted after word 5 of a drain -> out_valid=0 next cycle, voxel_count=0, next frame drains from word 0.
REQ-034 CNT_W=4, 20 beats in one frame -> voxel_count=15 (saturated).
